fifo_ctrl: RTL and testbench



---
 rtl/fifo_ctrl.sv | 87 ++++++++
 tb/tb_fifo_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Single-clock push/pop sequencer for a dual-port FIFO memory; optional sticky errors via FIFO_CTRL_ERR_EN.
// Latency: memory strobes combinational from push/pop, status flags registered one edge after acceptance.
// Backpressure: push dropped while full, pop dropped while empty; no write-through or bypass.
module fifo_ctrl #(
    parameter int depth     = 8,
    parameter int af_margin = 2,
    parameter int ae_margin = 2,
    localparam int AW       = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_write_addr,
    output logic          mem_read_en,
    output logic [AW-1:0] mem_read_addr,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(depth - af_margin);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(ae_margin);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_nxt;
    logic        push_acc;
    logic        pop_acc;

    // Gating by rst keeps the memory quiet for the whole reset cycle.
    assign push_acc = push & ~full & ~rst;
    assign pop_acc  = pop & ~empty & ~rst;

    assign mem_write_en   = push_acc;
    assign mem_write_addr = wr_ptr[AW-1:0];
    assign mem_read_en    = pop_acc;
    assign mem_read_addr  = rd_ptr[AW-1:0];

    assign count_nxt = count + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr + {{AW{1'b0}}, push_acc};
            rd_ptr       <= rd_ptr + {{AW{1'b0}}, pop_acc};
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_LVL);
            almost_empty <= (count_nxt <= AE_LVL);
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    // A new error in the clear cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push & full)  | (overflow  & ~err_clr);
            underflow <= (pop  & empty) | (underflow & ~err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small attached memory to follow data order.
module tb_fifo_ctrl;

    localparam int AW = 3;
`ifdef FIFO_CTRL_ERR_EN
    localparam int ERR = 1;
`else
    localparam int ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, push, pop, err_clr;
    logic          mem_write_en, mem_read_en;
    logic [AW-1:0] mem_write_addr, mem_read_addr;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    logic [7:0]    wdata;
    logic [7:0]    mem_arr [8];
    logic [7:0]    rdata;
    logic          rdata_vld;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.depth(8), .af_margin(2), .ae_margin(2)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .err_clr(err_clr),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always @(posedge clk) begin
        if (mem_write_en) mem_arr[mem_write_addr] <= wdata;
        if (mem_read_en) rdata <= mem_arr[mem_read_addr];
        rdata_vld <= mem_read_en;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle inputs/outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic p, input logic q, input logic c);
        push = p; pop = q; err_clr = c;
        #1;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        set_in(1, 1, 0);
        chk("rst_we", mem_write_en, 0);
        chk("rst_re", mem_read_en, 0);
        chk("rst_waddr", mem_write_addr, 0);
        chk("rst_raddr", mem_read_addr, 0);
        tick();
        chk("rst_push_discard", count, 0);

        // Fill to full.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 0);
            chk("fill_we", mem_write_en, 1);
            chk("fill_waddr", mem_write_addr, i);
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
            chk("fill_full", full, (i == 7) ? 1 : 0);
        end
        set_in(1, 0, 0);
        chk("ninth_we", mem_write_en, 0);
        tick();
        chk("ninth_count", count, 8);
        chk("ninth_ovf", overflow, ERR);

        // Full: push+pop -> pop only.
        set_in(1, 1, 0);
        chk("fullpp_re", mem_read_en, 1);
        chk("fullpp_raddr", mem_read_addr, 0);
        chk("fullpp_we", mem_write_en, 0);
        tick();
        chk("fullpp_count", count, 7);
        chk("fullpp_full", full, 0);
        chk("fullpp_af", almost_full, 1);

        set_in(0, 0, 1);
        tick();
        chk("ovf_clr", overflow, 0);

        // Wrap test from a fresh reset: push/pop pairs with data follow-through.
        rst = 1'b1; set_in(0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wdata = 8'hA0 + 8'(i);
            set_in(1, 0, 0);
            chk("wrap_waddr", mem_write_addr, i % 8);
            tick();
            chk("wrap_cnt1", count, 1);
            set_in(0, 1, 0);
            chk("wrap_re", mem_read_en, 1);
            chk("wrap_raddr", mem_read_addr, i % 8);
            tick();
            set_in(0, 0, 0);
            chk("wrap_vld", rdata_vld, 1);
            chk("wrap_data", rdata, 8'hA0 + i);
        end
        chk("wrap_empty", empty, 1);

        // Empty: push+pop -> push only, underflow.
        set_in(1, 1, 0);
        chk("emptypp_we", mem_write_en, 1);
        chk("emptypp_waddr", mem_write_addr, 4);
        chk("emptypp_re", mem_read_en, 0);
        tick();
        chk("emptypp_count", count, 1);
        chk("emptypp_unf", underflow, ERR);
        set_in(0, 0, 1);
        tick();
        chk("unf_clr", underflow, 0);

        // Drain, then error and clear together: set wins.
        set_in(0, 1, 0);
        tick();
        chk("drain_empty", empty, 1);
        set_in(0, 1, 1);
        tick();
        chk("unf_setwins", underflow, ERR);
        set_in(0, 0, 1);
        tick();

        // Five entries, then reset pulse.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0);
            tick();
        end
        chk("five_count", count, 5);
        rst = 1'b1; set_in(0, 0, 0);
        tick();
        rst = 1'b0;
        chk("prst_count", count, 0);
        chk("prst_empty", empty, 1);
        set_in(1, 0, 0);
        chk("prst_waddr", mem_write_addr, 0);
        tick();
        set_in(0, 1, 0);
        chk("prst_raddr", mem_read_addr, 0);
        tick();
        set_in(0, 0, 0);
        chk("prst_final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
